// File: rtl/half_adder.sv
// Half adder leaf cell: sum and carry of two bits.
// Ports: x, y operands; s = x ^ y; c = x & y.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/adder_1b.sv
// Single-bit full adder with generate/propagate terms and optional
// registered sum/carry.
// Ports: clk, rst (async, active-high) for the registered outputs only;
// a, b, cin operands; sum, cout, gen, prop combinational;
// sum_q, cout_q registered copies (tied low when REG_OUT = 0).
module adder_1b #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout,
    output logic gen,
    output logic prop,
    output logic sum_q,
    output logic cout_q
);

    logic pc;

    half_adder u_ha_ab (
        .x (a),
        .y (b),
        .s (prop),
        .c (gen)
    );

    half_adder u_ha_pc (
        .x (prop),
        .y (cin),
        .s (sum),
        .c (pc)
    );

    // Carry out: generated here, or an incoming carry propagated through.
    assign cout = gen | pc;

    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_q  <= 1'b0;
                    cout_q <= 1'b0;
                end else begin
                    sum_q  <= sum;
                    cout_q <= cout;
                end
            end
        end else begin : g_noreg
            // clk and rst have no load in this build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign sum_q  = 1'b0;
            assign cout_q = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_adder_1b.sv
// Self-checking bench for adder_1b, registered and unregistered builds.
// Directed vectors with hand-computed expectations.
module tb_adder_1b;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a   = 1'b0;
    logic b   = 1'b0;
    logic cin = 1'b0;

    logic sum, cout, gen, prop, sum_q, cout_q;
    logic sum0, cout0, gen0, prop0, sum_q0, cout_q0;

    int passed = 0;
    int total  = 0;

    adder_1b #(.REG_OUT(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout),
        .gen    (gen),
        .prop   (prop),
        .sum_q  (sum_q),
        .cout_q (cout_q)
    );

    adder_1b #(.REG_OUT(1'b0)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sum    (sum0),
        .cout   (cout0),
        .gen    (gen0),
        .prop   (prop0),
        .sum_q  (sum_q0),
        .cout_q (cout_q0)
    );

    // One rising then falling edge, 5 time units each phase.
    task automatic pulse();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if ({sum_q, cout_q} !== 2'b00)
            $display("FAIL reset_q: got %b%b want 00", sum_q, cout_q);
        else passed++;
        total++;
        if ({sum_q0, cout_q0} !== 2'b00)
            $display("FAIL reset_q0: got %b%b want 00", sum_q0, cout_q0);
        else passed++;
    endtask

    task automatic test_sweep();
        logic [7:0] exp_sum  = 8'b1001_0110;
        logic [7:0] exp_cout = 8'b1110_1000;
        logic [7:0] exp_gen  = 8'b1100_0000;
        logic [7:0] exp_prop = 8'b0011_1100;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            {a, b, cin} = v;
            #1;
            total++;
            if (sum !== exp_sum[i] || cout !== exp_cout[i])
                $display("FAIL sweep_%0d: sum/cout %b%b want %b%b",
                         i, sum, cout, exp_sum[i], exp_cout[i]);
            else passed++;
            total++;
            if (gen !== exp_gen[i] || prop !== exp_prop[i])
                $display("FAIL gp_%0d: gen/prop %b%b want %b%b",
                         i, gen, prop, exp_gen[i], exp_prop[i]);
            else passed++;
            total++;
            if (sum0 !== exp_sum[i] || cout0 !== exp_cout[i]
                || sum_q0 !== 1'b0 || cout_q0 !== 1'b0)
                $display("FAIL noreg_%0d: s c sq cq %b%b%b%b want %b%b00",
                         i, sum0, cout0, sum_q0, cout_q0,
                         exp_sum[i], exp_cout[i]);
            else passed++;
        end
    endtask

    task automatic test_gen_prop();
        {a, b, cin} = 3'b110;
        #1;
        total++;
        if (gen !== 1'b1 || prop !== 1'b0)
            $display("FAIL gp_110: gen/prop %b%b want 10", gen, prop);
        else passed++;
        {a, b, cin} = 3'b101;
        #1;
        total++;
        if (gen !== 1'b0 || prop !== 1'b1 || cout !== 1'b1)
            $display("FAIL gp_101: gen/prop/cout %b%b%b want 011",
                     gen, prop, cout);
        else passed++;
    endtask

    task automatic test_registered();
        rst = 1'b0;
        {a, b, cin} = 3'b111;
        #1;
        total++;
        if ({sum_q, cout_q} !== 2'b00)
            $display("FAIL reg_pre: got %b%b want 00", sum_q, cout_q);
        else passed++;
        #4 clk = 1'b1;
        #1;
        total++;
        if ({sum_q, cout_q} !== 2'b11)
            $display("FAIL reg_post: got %b%b want 11", sum_q, cout_q);
        else passed++;
        total++;
        if ({sum_q0, cout_q0} !== 2'b00)
            $display("FAIL reg_noreg: got %b%b want 00", sum_q0, cout_q0);
        else passed++;
        #4 clk = 1'b0;
    endtask

    task automatic test_async_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({sum_q, cout_q} !== 2'b00)
            $display("FAIL async_rst_q: got %b%b want 00", sum_q, cout_q);
        else passed++;
        total++;
        if ({sum, cout} !== 2'b11)
            $display("FAIL async_rst_comb: got %b%b want 11", sum, cout);
        else passed++;
        pulse();
        total++;
        if ({sum_q, cout_q} !== 2'b00)
            $display("FAIL rst_hold: got %b%b want 00", sum_q, cout_q);
        else passed++;
    endtask

    task automatic test_release();
        {a, b, cin} = 3'b010;
        rst = 1'b0;
        #1;
        total++;
        if ({sum_q, cout_q} !== 2'b00)
            $display("FAIL release_pre: got %b%b want 00", sum_q, cout_q);
        else passed++;
        pulse();
        total++;
        if ({sum_q, cout_q} !== 2'b10)
            $display("FAIL release_post: got %b%b want 10", sum_q, cout_q);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] vin [4]  = '{3'b011, 3'b000, 3'b111, 3'b100};
        logic [1:0] vexp [4] = '{2'b01, 2'b00, 2'b11, 2'b10};
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            {a, b, cin} = vin[i];
            pulse();
            total++;
            if ({sum_q, cout_q} !== vexp[i])
                $display("FAIL b2b_%0d: got %b%b want %b",
                         i, sum_q, cout_q, vexp[i]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_gen_prop();
        test_registered();
        test_async_reset();
        test_release();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
